noc_local_port: RTL

NOC_LOCAL_PORT -- requirements
Module: noc_local_port

---
 rtl/noc_pkg.sv | 42 ++++
 rtl/flit_fifo.sv | 82 ++++++++
 rtl/noc_local_port.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC local port: flit geometry, flit type codes,
// header field positions and the injection/ejection state encodings.
package noc_pkg;

   localparam int FLIT_W        = 18;
   localparam int FLITS_PER_PKT = 5;
   localparam int ID_W          = 4;
   localparam int PKT_NUM_W     = 8;

   localparam int TYPE_MSB      = 17;
   localparam int TYPE_LSB      = 16;
   localparam int HDR_DST_LSB   = 0;
   localparam int HDR_SRC_LSB   = 4;
   localparam int HDR_PKT_LSB   = 8;

   typedef enum logic [1:0] {
      FT_PAYLOAD = 2'b00,
      FT_HEADER  = 2'b01,
      FT_TAIL    = 2'b10
   } flit_type_e;

   typedef enum logic [1:0] {
      I_IDLE,
      I_ACK,
      I_RX
   } inj_state_e;

   typedef enum logic [1:0] {
      E_FILL,
      E_REQ,
      E_WAIT_LOW,
      E_TX
   } ej_state_e;

   // Position 0 is the header, the last position the tail, everything between is payload.
   function automatic flit_type_e expected_type(input logic [2:0] idx);
      if (idx == 3'd0) return FT_HEADER;
      if (idx == 3'(FLITS_PER_PKT - 1)) return FT_TAIL;
      return FT_PAYLOAD;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with a speculative (staging) write pointer that is either
// committed, making staged flits readable, or rolled back to discard them.
module flit_fifo
   import noc_pkg::*;
#(
   parameter int W     = FLIT_W,
   parameter int DEPTH = 10
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en_i,
   input  logic [W-1:0]                 wr_data_i,
   input  logic                         commit_i,
   input  logic                         rollback_i,
   input  logic                         rd_en_i,
   output logic [W-1:0]                 rd_data_o,
   output logic                         rd_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   free_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] cwr_ptr_q, cwr_ptr_d;
   logic [PW-1:0] swr_ptr_q, swr_ptr_d;
   logic [CW-1:0] ccount_q, ccount_d;
   logic [CW-1:0] scount_q, scount_d;
   logic [PW-1:0] swr_after;
   logic [CW-1:0] scount_after;
   logic          pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop        = rd_en_i && (ccount_q != '0);
   assign rd_valid_o = (ccount_q != '0);
   assign rd_data_o  = mem[rd_ptr_q];
   assign free_o     = CW'(DEPTH) - ccount_q - scount_q;

   // A commit includes a flit written in the same cycle; a rollback drops it.
   always_comb begin
      swr_after    = wr_en_i ? ptr_next(swr_ptr_q) : swr_ptr_q;
      scount_after = scount_q + CW'(wr_en_i);
      rd_ptr_d     = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
      cwr_ptr_d    = cwr_ptr_q;
      swr_ptr_d    = swr_after;
      scount_d     = scount_after;
      ccount_d     = ccount_q - CW'(pop);
      if (commit_i) begin
         cwr_ptr_d = swr_after;
         ccount_d  = ccount_q - CW'(pop) + scount_after;
         scount_d  = '0;
      end else if (rollback_i) begin
         swr_ptr_d = cwr_ptr_q;
         scount_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q  <= '0;
         cwr_ptr_q <= '0;
         swr_ptr_q <= '0;
         ccount_q  <= '0;
         scount_q  <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         cwr_ptr_q <= cwr_ptr_d;
         swr_ptr_q <= swr_ptr_d;
         ccount_q  <= ccount_d;
         scount_q  <= scount_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) mem[swr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/noc_local_port.sv
// Local port between a node and the router core: validated packet injection
// through a commit/rollback buffer, and single-packet ejection with a req/ack handshake.
module noc_local_port
   import noc_pkg::*;
#(
   parameter logic [ID_W-1:0] NODE_ID   = '0,
   parameter int              PKT_DEPTH = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              inj_req,
   output logic              inj_ack,
   input  logic [FLIT_W-1:0] inj_data,
   output logic              ej_req,
   input  logic              ej_ack,
   output logic [FLIT_W-1:0] ej_data,
   output logic [FLIT_W-1:0] rtr_out_flit,
   output logic              rtr_out_valid,
   input  logic              rtr_out_ready,
   input  logic [FLIT_W-1:0] rtr_in_flit,
   input  logic              rtr_in_valid,
   output logic              rtr_in_ready,
   output logic              fmt_err
);

   localparam int DEPTH = PKT_DEPTH * FLITS_PER_PKT;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [2:0] LAST = 3'(FLITS_PER_PKT - 1);

   inj_state_e    inj_state_q, inj_state_d;
   logic [2:0]    rx_cnt_q, rx_cnt_d;
   logic          fmt_ok_q, fmt_ok_d;
   logic          fmt_err_q, fmt_err_d;
   logic          flit_ok, fifo_wr, fifo_commit, fifo_rollback;
   logic [CW-1:0] free_flits;

   flit_fifo #(
      .W     (FLIT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (fifo_wr),
      .wr_data_i  (inj_data),
      .commit_i   (fifo_commit),
      .rollback_i (fifo_rollback),
      .rd_en_i    (rtr_out_ready),
      .rd_data_o  (rtr_out_flit),
      .rd_valid_o (rtr_out_valid),
      .free_o     (free_flits)
   );

   assign inj_ack = (inj_state_q == I_ACK);
   assign fmt_err = fmt_err_q;

   // The packet verdict is decided on the tail edge, so the tail write and commit coincide.
   always_comb begin
      inj_state_d   = inj_state_q;
      rx_cnt_d      = rx_cnt_q;
      fmt_ok_d      = fmt_ok_q;
      fmt_err_d     = 1'b0;
      fifo_wr       = 1'b0;
      fifo_commit   = 1'b0;
      fifo_rollback = 1'b0;
      flit_ok       = (inj_data[TYPE_MSB:TYPE_LSB] == expected_type(rx_cnt_q));
      if ((rx_cnt_q == 3'd0) && (inj_data[HDR_SRC_LSB +: ID_W] != NODE_ID)) flit_ok = 1'b0;
      case (inj_state_q)
         I_IDLE: begin
            if (inj_req && (free_flits >= CW'(FLITS_PER_PKT))) inj_state_d = I_ACK;
         end
         I_ACK: begin
            if (!inj_req) begin
               inj_state_d = I_RX;
               rx_cnt_d    = '0;
               fmt_ok_d    = 1'b1;
            end
         end
         I_RX: begin
            fifo_wr  = 1'b1;
            fmt_ok_d = fmt_ok_q & flit_ok;
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == LAST) begin
               inj_state_d   = I_IDLE;
               fifo_commit   = fmt_ok_q & flit_ok;
               fifo_rollback = ~(fmt_ok_q & flit_ok);
               fmt_err_d     = ~(fmt_ok_q & flit_ok);
            end
         end
         default: inj_state_d = I_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inj_state_q <= I_IDLE;
         rx_cnt_q    <= '0;
         fmt_ok_q    <= 1'b1;
         fmt_err_q   <= 1'b0;
      end else begin
         inj_state_q <= inj_state_d;
         rx_cnt_q    <= rx_cnt_d;
         fmt_ok_q    <= fmt_ok_d;
         fmt_err_q   <= fmt_err_d;
      end
   end

   ej_state_e         ej_state_q, ej_state_d;
   logic [2:0]        fill_cnt_q, fill_cnt_d;
   logic [2:0]        tx_idx_q, tx_idx_d;
   logic [FLIT_W-1:0] ej_data_q, ej_data_d;
   logic              in_ready_q, in_ready_d;
   logic [FLIT_W-1:0] ej_buf_q [FLITS_PER_PKT];
   logic              accept;

   assign accept       = rtr_in_valid && in_ready_q;
   assign rtr_in_ready = in_ready_q;
   assign ej_req       = (ej_state_q == E_REQ);
   assign ej_data      = ej_data_q;

   // Ready is registered so it stays low during reset and rises on the first edge after.
   always_comb begin
      ej_state_d = ej_state_q;
      fill_cnt_d = fill_cnt_q;
      tx_idx_d   = tx_idx_q;
      ej_data_d  = ej_data_q;
      case (ej_state_q)
         E_FILL: begin
            if (accept) begin
               fill_cnt_d = fill_cnt_q + 3'd1;
               if (fill_cnt_q == LAST) begin
                  ej_state_d = E_REQ;
                  fill_cnt_d = '0;
                  ej_data_d  = ej_buf_q[0];
               end
            end
         end
         E_REQ: begin
            if (ej_ack) ej_state_d = E_WAIT_LOW;
         end
         E_WAIT_LOW: begin
            if (!ej_ack) begin
               ej_state_d = E_TX;
               ej_data_d  = ej_buf_q[1];
               tx_idx_d   = 3'd2;
            end
         end
         E_TX: begin
            if (tx_idx_q == 3'(FLITS_PER_PKT)) begin
               ej_state_d = E_FILL;
            end else begin
               ej_data_d = ej_buf_q[tx_idx_q];
               tx_idx_d  = tx_idx_q + 3'd1;
            end
         end
         default: ej_state_d = E_FILL;
      endcase
      in_ready_d = (ej_state_d == E_FILL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ej_state_q <= E_FILL;
         fill_cnt_q <= '0;
         tx_idx_q   <= '0;
         ej_data_q  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         ej_state_q <= ej_state_d;
         fill_cnt_q <= fill_cnt_d;
         tx_idx_q   <= tx_idx_d;
         ej_data_q  <= ej_data_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) ej_buf_q[fill_cnt_q] <= rtr_in_flit;
   end

endmodule
